d5m_capture: RTL

Pixel capture front end for the D5M sensor, directly downstream of the sensor's I2C register configuration stage. Waits for configuration to finish and software to arm it, aligns to a frame boundary, then turns the sensor's FVAL/LVAL/DATA bus into a registered pixel stream. The stream carries start-of-frame, end-of-line and end-of-frame markers plus pixel, line and frame counters for the downstream Bayer/buffer stages.

---
 rtl/d5m_pkg.sv | 16 +
 rtl/d5m_bus_sync.sv | 76 +++++++
 rtl/d5m_capture.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/d5m_pkg.sv
// Shared definitions for the D5M capture front end: capture FSM state
// encodings and default geometry / pixel width of the binned sensor window.
package d5m_pkg;

  localparam int D5M_DATA_W   = 12;
  localparam int D5M_H_ACTIVE = 1280;
  localparam int D5M_V_ACTIVE = 960;
  localparam int D5M_CNT_W    = 12;

  typedef logic [1:0] cap_state_t;

  localparam cap_state_t ST_IDLE    = 2'd0;
  localparam cap_state_t ST_ARMED   = 2'd1;
  localparam cap_state_t ST_CAPTURE = 2'd2;

endpackage

// File: rtl/d5m_bus_sync.sv
// Two-stage register for the sensor FVAL/LVAL/DATA bus, with edge flags
// derived from the second stage against the sample before it.
module d5m_bus_sync
  import d5m_pkg::*;
#(
  parameter int DATA_W = D5M_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fval_in,
  input  logic              lval_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              s1_fval,
  output logic              s1_lval,
  output logic              s2_fval,
  output logic              s2_lval,
  output logic [DATA_W-1:0] s2_data,
  output logic              fval_rise,
  output logic              fval_fall,
  output logic              lval_rise
);

  logic              s1_fval_q, s1_fval_d, s1_lval_q, s1_lval_d;
  logic              s2_fval_q, s2_fval_d, s2_lval_q, s2_lval_d;
  logic              s3_fval_q, s3_fval_d, s3_lval_q, s3_lval_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d, s2_data_q, s2_data_d;
  logic [2:0]        fill_q, fill_d;

  always_comb begin
    s1_fval_d = fval_in;
    s1_lval_d = lval_in;
    s1_data_d = data_in;
    s2_fval_d = s1_fval_q;
    s2_lval_d = s1_lval_q;
    s2_data_d = s1_data_q;
    s3_fval_d = s2_fval_q;
    s3_lval_d = s2_lval_q;
    fill_d    = {fill_q[1:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_fval_q <= 1'b0;
      s1_lval_q <= 1'b0;
      s1_data_q <= '0;
      s2_fval_q <= 1'b0;
      s2_lval_q <= 1'b0;
      s2_data_q <= '0;
      s3_fval_q <= 1'b0;
      s3_lval_q <= 1'b0;
      fill_q    <= '0;
    end else begin
      s1_fval_q <= s1_fval_d;
      s1_lval_q <= s1_lval_d;
      s1_data_q <= s1_data_d;
      s2_fval_q <= s2_fval_d;
      s2_lval_q <= s2_lval_d;
      s2_data_q <= s2_data_d;
      s3_fval_q <= s3_fval_d;
      s3_lval_q <= s3_lval_d;
      fill_q    <= fill_d;
    end
  end

  // Edges are only trusted once the prior sample is a real pin sample, so a
  // frame already in progress at reset release never looks like a rise.
  assign s1_fval   = s1_fval_q;
  assign s1_lval   = s1_lval_q;
  assign s2_fval   = s2_fval_q;
  assign s2_lval   = s2_lval_q;
  assign s2_data   = s2_data_q;
  assign fval_rise = fill_q[2] & s2_fval_q & ~s3_fval_q;
  assign fval_fall = fill_q[2] & ~s2_fval_q & s3_fval_q;
  assign lval_rise = fill_q[2] & s2_lval_q & ~s3_lval_q;

endmodule

// File: rtl/d5m_capture.sv
// D5M pixel capture: arm after configuration, align to frame start, emit a
// registered pixel stream with sof/eol/eof and x/y/frame counters.
// Optional D5M_CAPTURE_SIZE_CHECK_EN adds a sticky line/frame size check.
module d5m_capture
  import d5m_pkg::*;
#(
  parameter int DATA_W   = D5M_DATA_W,
  parameter int H_ACTIVE = D5M_H_ACTIVE,
  parameter int V_ACTIVE = D5M_V_ACTIVE,
  parameter int CNT_W    = D5M_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              config_done,
  input  logic              capture_en,
  input  logic              fval,
  input  logic              lval,
  input  logic [DATA_W-1:0] pix_data,
  output logic [DATA_W-1:0] pix_out,
  output logic              pix_valid,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic [CNT_W-1:0]  x_cnt,
  output logic [CNT_W-1:0]  y_cnt,
  output logic [15:0]       frame_cnt,
  output logic              busy,
  output logic              frame_err
);

  logic              s1_fval, s1_lval, s2_fval, s2_lval;
  logic [DATA_W-1:0] s2_data;
  logic              fval_rise, fval_fall, lval_rise;

  d5m_bus_sync #(.DATA_W(DATA_W)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .fval_in   (fval),
    .lval_in   (lval),
    .data_in   (pix_data),
    .s1_fval   (s1_fval),
    .s1_lval   (s1_lval),
    .s2_fval   (s2_fval),
    .s2_lval   (s2_lval),
    .s2_data   (s2_data),
    .fval_rise (fval_rise),
    .fval_fall (fval_fall),
    .lval_rise (lval_rise)
  );

  cap_state_t        state_q, state_d;
  logic [CNT_W-1:0]  x_run_q, x_run_d, y_run_q, y_run_d, x_idx;
  logic              sof_pend_q, sof_pend_d;
  logic [DATA_W-1:0] pix_out_q, pix_out_d;
  logic              pix_valid_q, pix_valid_d, sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
  logic [CNT_W-1:0]  x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              err_q, err_d;
  logic              cfg_ok, start, in_cap, valid, last, frame_end;

  always_comb begin
    cfg_ok    = config_done & capture_en;
    start     = (state_q == ST_ARMED) & cfg_ok & fval_rise;
    // Losing config_done aborts at once, so it also gates the pixel path.
    in_cap    = start | ((state_q == ST_CAPTURE) & config_done);
    valid     = in_cap & s2_lval & s2_fval;
    last      = valid & (~s1_lval | ~s1_fval);
    x_idx     = lval_rise ? '0 : x_run_q;
    frame_end = (state_q == ST_CAPTURE) & config_done & fval_fall;

    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (cfg_ok) state_d = ST_ARMED;
      ST_ARMED: begin
        if (!cfg_ok)        state_d = ST_IDLE;
        else if (fval_rise) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (!config_done)   state_d = ST_IDLE;
        else if (fval_fall) state_d = capture_en ? ST_ARMED : ST_IDLE;
      end
      default:              state_d = ST_IDLE;
    endcase

    x_run_d    = x_run_q;
    y_run_d    = y_run_q;
    sof_pend_d = sof_pend_q | start;
    if (!in_cap) begin
      x_run_d    = '0;
      y_run_d    = '0;
      sof_pend_d = 1'b0;
    end else begin
      if (valid) begin
        x_run_d    = last ? '0 : x_idx + CNT_W'(1);
        sof_pend_d = 1'b0;
      end
      if (last) y_run_d = y_run_q + CNT_W'(1);
    end

    pix_valid_d = valid;
    sof_d       = valid & (sof_pend_q | start);
    eol_d       = last;
    eof_d       = frame_end;
    pix_out_d   = valid ? s2_data : pix_out_q;
    x_cnt_d     = valid ? x_idx : x_cnt_q;
    y_cnt_d     = valid ? y_run_q : y_cnt_q;
    frame_cnt_d = frame_cnt_q + 16'(frame_end);

`ifdef D5M_CAPTURE_SIZE_CHECK_EN
    err_d = err_q
          | (last & (x_idx + CNT_W'(1) != CNT_W'(H_ACTIVE)))
          | (frame_end & (y_run_q != CNT_W'(V_ACTIVE)));
`else
    err_d = 1'b0;
`endif
  end

`ifndef D5M_CAPTURE_SIZE_CHECK_EN
  localparam int unused_geometry = H_ACTIVE + V_ACTIVE;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x_run_q     <= '0;
      y_run_q     <= '0;
      sof_pend_q  <= 1'b0;
      pix_out_q   <= '0;
      pix_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_run_q     <= x_run_d;
      y_run_q     <= y_run_d;
      sof_pend_q  <= sof_pend_d;
      pix_out_q   <= pix_out_d;
      pix_valid_q <= pix_valid_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      eof_q       <= eof_d;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

  assign pix_out   = pix_out_q;
  assign pix_valid = pix_valid_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign eof       = eof_q;
  assign x_cnt     = x_cnt_q;
  assign y_cnt     = y_cnt_q;
  assign frame_cnt = frame_cnt_q;
  assign busy      = (state_q == ST_CAPTURE);
  assign frame_err = err_q;

endmodule
